// File: rtl/ppu_lcd_pkg.sv
// ppu_lcd_pkg: shared constants and types for the LCD scan-out stage.
//   - default 800x480 panel timing and derived H_TOTAL / V_TOTAL
//   - source image size (256x240) and image window placement
//   - palette entry and timing bundle types
// Build option: PPU_LCD_SCALE2X_EN selects 2x pixel doubling (512x480 window
// at column 144). Without it the image is shown 1:1, centred at (272,120).
package ppu_lcd_pkg;

    localparam int H_ACTIVE_DEF = 800;
    localparam int H_FP_DEF     = 40;
    localparam int H_SYNC_DEF   = 48;
    localparam int H_BP_DEF     = 40;
    localparam int V_ACTIVE_DEF = 480;
    localparam int V_FP_DEF     = 13;
    localparam int V_SYNC_DEF   = 3;
    localparam int V_BP_DEF     = 29;

    localparam int H_TOTAL = H_ACTIVE_DEF + H_FP_DEF + H_SYNC_DEF + H_BP_DEF;  // 928
    localparam int V_TOTAL = V_ACTIVE_DEF + V_FP_DEF + V_SYNC_DEF + V_BP_DEF;  // 525

    // Counter width leaves headroom over the default totals.
    localparam int CNT_W = 11;

    localparam int IMG_SRC_W = 256;
    localparam int IMG_SRC_H = 240;

`ifdef PPU_LCD_SCALE2X_EN
    localparam int IMG_SCALE_SH = 1;
    localparam int IMG_HOFF_DEF = 144;
    localparam int IMG_VOFF_DEF = 0;
`else
    localparam int IMG_SCALE_SH = 0;
    localparam int IMG_HOFF_DEF = 272;
    localparam int IMG_VOFF_DEF = 120;
`endif

    localparam int IMG_W = IMG_SRC_W << IMG_SCALE_SH;
    localparam int IMG_H = IMG_SRC_H << IMG_SCALE_SH;

    typedef struct packed {
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
    } pal_rgb_t;

    typedef struct packed {
        logic hs;
        logic vs;
        logic de;
    } lcd_tmg_t;

    localparam lcd_tmg_t TMG_IDLE = '{hs: 1'b1, vs: 1'b1, de: 1'b0};

endpackage

// File: rtl/ppu_lcd_palette.sv
// ppu_lcd_palette: 64-entry NES palette ROM with registered output.
//   i_lcd_clk / i_rstn : clock, async active-low reset
//   i_idx  [5:0]       : NES colour index
//   i_win              : pixel is inside the image window; outside -> black
//   o_rgb  pal_rgb_t   : colour, one clock after i_idx
module ppu_lcd_palette
    import ppu_lcd_pkg::*;
(
    input  logic       i_lcd_clk,
    input  logic       i_rstn,
    input  logic [5:0] i_idx,
    input  logic       i_win,
    output pal_rgb_t   o_rgb
);

    localparam logic [23:0] PAL_ROM [64] = '{
        24'h7C7C7C, 24'h0000FC, 24'h0000BC, 24'h4428BC, 24'h940084, 24'hA80020, 24'hA81000, 24'h881400,
        24'h503000, 24'h007800, 24'h006800, 24'h005800, 24'h004058, 24'h000000, 24'h000000, 24'h000000,
        24'hBCBCBC, 24'h0078F8, 24'h0058F8, 24'h6844FC, 24'hD800CC, 24'hE40058, 24'hF83800, 24'hE45C10,
        24'hAC7C00, 24'h00B800, 24'h00A800, 24'h00A844, 24'h008888, 24'h000000, 24'h000000, 24'h000000,
        24'hF8F8F8, 24'h3CBCFC, 24'h6888FC, 24'h9878F8, 24'hF878F8, 24'hF85898, 24'hF87858, 24'hFCA044,
        24'hF8B800, 24'hB8F818, 24'h58D854, 24'h58F898, 24'h00E8D8, 24'h787878, 24'h000000, 24'h000000,
        24'hFCFCFC, 24'hA4E4FC, 24'hB8B8F8, 24'hD8B8F8, 24'hF8B8F8, 24'hF8A4C0, 24'hF0D0B0, 24'hFCE0A8,
        24'hF8D878, 24'hD8F878, 24'hB8F8B8, 24'hB8F8D8, 24'h00FCFC, 24'hF8D8F8, 24'h000000, 24'h000000
    };

    pal_rgb_t rgb_d, rgb_q;

    always_comb begin
        rgb_d = '0;
        if (i_win) rgb_d = pal_rgb_t'(PAL_ROM[i_idx]);
    end

    always_ff @(posedge i_lcd_clk or negedge i_rstn) begin
        if (!i_rstn) rgb_q <= '0;
        else         rgb_q <= rgb_d;
    end

    assign o_rgb = rgb_q;

endmodule

// File: rtl/ppu_lcd_scan.sv
// ppu_lcd_scan: LCD scan-out stage behind the PPU double video buffer.
//   i_lcd_clk, i_rstn      : pixel clock, async active-low reset
//   i_wbuf_sel             : buffer the PPU is writing (other clock domain)
//   o_raddr [16:0]         : {rd_buf, y[7:0], x[7:0]} buffer read address
//   i_rdata [7:0]          : read data, one clock after o_raddr (bits 7:6 unused)
//   o_lcd_hs/vs/de         : panel timing, hs/vs active low
//   o_lcd_r/g/b [7:0]      : pixel colour
// All LCD outputs lag the counters by 3 clocks:
//   counters -> (1) address/window -> (2) buffer data -> (3) palette RGB.
// Build option: PPU_LCD_SCALE2X_EN (2x pixel doubling, see ppu_lcd_pkg).
module ppu_lcd_scan
    import ppu_lcd_pkg::*;
#(
    parameter int H_ACTIVE = H_ACTIVE_DEF,
    parameter int H_FP     = H_FP_DEF,
    parameter int H_SYNC   = H_SYNC_DEF,
    parameter int H_BP     = H_BP_DEF,
    parameter int V_ACTIVE = V_ACTIVE_DEF,
    parameter int V_FP     = V_FP_DEF,
    parameter int V_SYNC   = V_SYNC_DEF,
    parameter int V_BP     = V_BP_DEF,
    parameter int IMG_HOFF = IMG_HOFF_DEF,
    parameter int IMG_VOFF = IMG_VOFF_DEF
) (
    input  logic        i_lcd_clk,
    input  logic        i_rstn,
    input  logic        i_wbuf_sel,
    output logic [16:0] o_raddr,
    input  logic [7:0]  i_rdata,
    output logic        o_lcd_hs,
    output logic        o_lcd_vs,
    output logic        o_lcd_de,
    output logic [7:0]  o_lcd_r,
    output logic [7:0]  o_lcd_g,
    output logic [7:0]  o_lcd_b
);

    localparam logic [CNT_W-1:0] H_LAST = CNT_W'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
    localparam logic [CNT_W-1:0] V_LAST = CNT_W'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);
    localparam logic [CNT_W-1:0] H_ACT  = CNT_W'(H_ACTIVE);
    localparam logic [CNT_W-1:0] V_ACT  = CNT_W'(V_ACTIVE);
    localparam logic [CNT_W-1:0] HS_BEG = CNT_W'(H_ACTIVE + H_FP);
    localparam logic [CNT_W-1:0] HS_END = CNT_W'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [CNT_W-1:0] VS_BEG = CNT_W'(V_ACTIVE + V_FP);
    localparam logic [CNT_W-1:0] VS_END = CNT_W'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [CNT_W-1:0] WIN_X0 = CNT_W'(IMG_HOFF);
    localparam logic [CNT_W-1:0] WIN_X1 = CNT_W'(IMG_HOFF + IMG_W);
    localparam logic [CNT_W-1:0] WIN_Y0 = CNT_W'(IMG_VOFF);
    localparam logic [CNT_W-1:0] WIN_Y1 = CNT_W'(IMG_VOFF + IMG_H);

    logic [CNT_W-1:0]   hcnt_d, hcnt_q, vcnt_d, vcnt_q;
    logic [1:0]         wsync_d, wsync_q;
    logic               rd_buf_d, rd_buf_q;
    logic [16:0]        raddr_d, raddr_q;
    logic               win1_d, win1_q, win2_d, win2_q;
    lcd_tmg_t [2:0]     tmg_d, tmg_q;
    lcd_tmg_t           tmg0;
    logic               win0;
    logic [7:0]         img_x, img_y;
    logic [1:0]         rdata_unused;
    pal_rgb_t           pix_rgb;

    assign rdata_unused = i_rdata[7:6];

    always_comb begin
        hcnt_d = hcnt_q + 1'b1;
        vcnt_d = vcnt_q;
        if (hcnt_q == H_LAST) begin
            hcnt_d = '0;
            vcnt_d = (vcnt_q == V_LAST) ? '0 : vcnt_q + 1'b1;
        end

        // rd_buf only moves at frame start so a frame is read from one buffer.
        wsync_d  = {wsync_q[0], i_wbuf_sel};
        rd_buf_d = rd_buf_q;
        if (hcnt_q == '0 && vcnt_q == '0) rd_buf_d = ~wsync_q[1];

        tmg0.de = (hcnt_q < H_ACT) && (vcnt_q < V_ACT);
        tmg0.hs = !((hcnt_q >= HS_BEG) && (hcnt_q < HS_END));
        tmg0.vs = !((vcnt_q >= VS_BEG) && (vcnt_q < VS_END));

        win0  = (hcnt_q >= WIN_X0) && (hcnt_q < WIN_X1) &&
                (vcnt_q >= WIN_Y0) && (vcnt_q < WIN_Y1);
        img_x = 8'((hcnt_q - WIN_X0) >> IMG_SCALE_SH);
        img_y = 8'((vcnt_q - WIN_Y0) >> IMG_SCALE_SH);

        raddr_d = {rd_buf_q, win0 ? {img_y, img_x} : 16'h0};
        win1_d  = win0;
        win2_d  = win1_q;
        tmg_d   = {tmg_q[1:0], tmg0};
    end

    always_ff @(posedge i_lcd_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            hcnt_q   <= '0;
            vcnt_q   <= '0;
            wsync_q  <= '0;
            rd_buf_q <= 1'b0;
            raddr_q  <= '0;
            win1_q   <= 1'b0;
            win2_q   <= 1'b0;
            tmg_q    <= {3{TMG_IDLE}};
        end else begin
            hcnt_q   <= hcnt_d;
            vcnt_q   <= vcnt_d;
            wsync_q  <= wsync_d;
            rd_buf_q <= rd_buf_d;
            raddr_q  <= raddr_d;
            win1_q   <= win1_d;
            win2_q   <= win2_d;
            tmg_q    <= tmg_d;
        end
    end

    // Stage 2 -> 3: buffer data indexes the palette; border pixels come out black.
    ppu_lcd_palette u_pal (
        .i_lcd_clk (i_lcd_clk),
        .i_rstn    (i_rstn),
        .i_idx     (i_rdata[5:0]),
        .i_win     (win2_q),
        .o_rgb     (pix_rgb)
    );

    assign o_raddr  = raddr_q;
    assign o_lcd_hs = tmg_q[2].hs;
    assign o_lcd_vs = tmg_q[2].vs;
    assign o_lcd_de = tmg_q[2].de;
    assign o_lcd_r  = pix_rgb.r;
    assign o_lcd_g  = pix_rgb.g;
    assign o_lcd_b  = pix_rgb.b;

endmodule

// File: tb/tb_ppu_lcd_scan.sv
// tb_ppu_lcd_scan: scoreboard bench for ppu_lcd_scan with a short vertical
// timing (14 lines per frame) so several frames fit in a short run.
module tb_ppu_lcd_scan;

    localparam int HT = 928;
    localparam int VA = 8, VF = 2, VS = 2, VB = 2;
    localparam int VT = VA + VF + VS + VB;
`ifdef PPU_LCD_SCALE2X_EN
    localparam int SH = 1, HOFF = 144, VOFF = 0, WW = 512, WH = 480;
`else
    localparam int SH = 0, HOFF = 272, VOFF = 2, WW = 256, WH = 240;
`endif

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        wbuf_sel = 1'b0;
    logic [7:0]  rdata = 8'h00;
    logic [16:0] raddr;
    logic        hs, vs, de;
    logic [7:0]  r, g, b;

    ppu_lcd_scan #(
        .V_ACTIVE (VA), .V_FP (VF), .V_SYNC (VS), .V_BP (VB), .IMG_VOFF (VOFF)
    ) dut (
        .i_lcd_clk  (clk),
        .i_rstn     (rstn),
        .i_wbuf_sel (wbuf_sel),
        .o_raddr    (raddr),
        .i_rdata    (rdata),
        .o_lcd_hs   (hs),
        .o_lcd_vs   (vs),
        .o_lcd_de   (de),
        .o_lcd_r    (r),
        .o_lcd_g    (g),
        .o_lcd_b    (b)
    );

    always #5 clk = ~clk;

    typedef struct { int due; logic [16:0] a; } addr_exp_t;
    typedef struct { int due; logic [2:0] tmg; logic [23:0] rgb; } pix_exp_t;

    addr_exp_t   aq[$];
    pix_exp_t    pq[$];
    int          total = 0, bad = 0;
    int          k = 0;
    logic        cur_buf = 1'b0, prev_buf = 1'b0;
    logic [16:0] addr_lat = '0;

    // Buffer contents: one of four known colours, with junk in bits 7:6.
    function automatic logic [7:0] mem_f(input logic [16:0] a);
        logic [1:0] s;
        logic [5:0] idx;
        s = a[3:2] ^ a[9:8];
        case (s)
            2'd0:    idx = 6'h00;
            2'd1:    idx = 6'h16;
            2'd2:    idx = 6'h30;
            default: idx = 6'h21;
        endcase
        return {a[1:0], idx};
    endfunction

    function automatic logic [23:0] pal_ref(input logic [5:0] idx);
        case (idx)
            6'h00:   return 24'h7C7C7C;
            6'h16:   return 24'hF83800;
            6'h30:   return 24'hFCFCFC;
            6'h21:   return 24'h3CBCFC;
            default: return 24'hDEAD00;
        endcase
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s k=%0d observed=%h expected=%h", tag, k, obs, exp);
        end
    endtask

    // Expected results for the counter position of cycle k.
    task automatic push_exp();
        int          h, v;
        logic        bsel, win;
        logic [16:0] a;
        logic [7:0]  d;
        addr_exp_t   ae;
        pix_exp_t    pe;
        h = k % HT;
        v = (k / HT) % VT;
        if (h == 0 && v == 0) begin
            prev_buf = cur_buf;
            cur_buf  = (k == 0) ? 1'b1 : ~wbuf_sel;
        end
        bsel = (h == 0 && v == 0) ? prev_buf : cur_buf;
        win  = (h >= HOFF) && (h < HOFF + WW) && (v >= VOFF) && (v < VOFF + WH);
        a    = win ? {bsel, 8'((v - VOFF) >> SH), 8'((h - HOFF) >> SH)} : {bsel, 16'h0};
        d    = mem_f(a);
        ae.due = k + 1;
        ae.a   = a;
        aq.push_back(ae);
        pe.due = k + 3;
        pe.tmg = {!(h >= 840 && h < 888), !(v >= VA + VF && v < VA + VF + VS), (h < 800 && v < VA)};
        pe.rgb = win ? pal_ref(d[5:0]) : 24'h0;
        pq.push_back(pe);
    endtask

    task automatic run_cycles(input int n);
        addr_exp_t ae;
        pix_exp_t  pe;
        for (int i = 0; i < n; i++) begin
            push_exp();
            @(posedge clk);
            #1;
            k++;
            rdata    = mem_f(addr_lat);   // models the registered buffer read
            addr_lat = raddr;
            while (aq.size() > 0 && aq[0].due == k) begin
                ae = aq.pop_front();
                chk("raddr", 32'(raddr), 32'(ae.a));
            end
            while (pq.size() > 0 && pq[0].due == k) begin
                pe = pq.pop_front();
                chk("hs_vs_de", 32'({hs, vs, de}), 32'(pe.tmg));
                chk("rgb", 32'({r, g, b}), 32'(pe.rgb));
            end
        end
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_raddr"}, 32'(raddr), 32'h0);
        chk({tag, "_hs_vs_de"}, 32'({hs, vs, de}), 32'b110);
        chk({tag, "_rgb"}, 32'({r, g, b}), 32'h0);
    endtask

    task automatic restart();
        aq.delete();
        pq.delete();
        k        = 0;
        cur_buf  = 1'b0;
        prev_buf = 1'b0;
    endtask

    initial begin
        // Power-on reset.
        repeat (3) @(negedge clk);
        chk_reset_vals("por");
        rstn = 1'b1;
        restart();

        // Frame 0 and the first lines of frame 1 with wbuf_sel = 0 (reads buffer 1).
        run_cycles(HT * VT + 5 * HT);
        // PPU flips its write buffer mid-frame: takes effect only at frame 2.
        wbuf_sel = 1'b1;
        run_cycles(HT * VT - 5 * HT + 3 * HT + 300);

        // Asynchronous reset mid-line at hcnt = 300.
        #2;
        rstn = 1'b0;
        #1;
        chk_reset_vals("midrst");
        repeat (3) @(negedge clk);
        chk_reset_vals("midrst_hold");
        rstn = 1'b1;
        restart();

        // de stays low for the first two edges, rises on the third.
        run_cycles(1);
        chk("de_edge1", 32'(de), 32'h0);
        run_cycles(1);
        chk("de_edge2", 32'(de), 32'h0);
        run_cycles(2 * HT);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
